// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image byte by byte, writes it
// into program memory as little-endian 32-bit words and releases the CPU from
// reset only after the image checksum verifies.
module uart_boot_loader #(
  parameter int unsigned ADDR_W  = 9,
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen0 = 3'd1;
  localparam logic [2:0] StLen1 = 3'd2;
  localparam logic [2:0] StData = 3'd3;
  localparam logic [2:0] StCsum = 3'd4;
  localparam logic [2:0] StDone = 3'd5;
  localparam logic [2:0] StErr  = 3'd6;

  // Largest word count that still fits the target memory.
  localparam logic [16:0] MaxWords = 17'd1 << ADDR_W;
  localparam logic [31:0] IdleLast = 32'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       idle_q, idle_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        in_image;
  logic [7:0]  sum_next;
  logic [15:0] len_new;

  assign in_image = (state_q == StLen0) || (state_q == StLen1) ||
                    (state_q == StData) || (state_q == StCsum);
  assign sum_next = csum_q + rx_data;
  assign len_new  = {rx_data, len_q[7:0]};

  // Next-state logic: frame parsing, word assembly and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    widx_d      = widx_q;
    bidx_d      = bidx_q;
    wbuf_d      = wbuf_q;
    csum_d      = csum_q;
    idle_d      = '0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (in_image && !rx_valid) begin
      idle_d = idle_q + 32'd1;
    end

    case (state_q)
      StIdle, StErr: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          state_d = StLen0;
          csum_d  = '0;
        end
      end
      StLen0: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          csum_d     = sum_next;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          csum_d      = sum_next;
          widx_d      = '0;
          bidx_d      = '0;
          if (len_new == 16'd0) begin
            state_d = StCsum;
          end else if ({1'b0, len_new} > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          csum_d = sum_next;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: wbuf_d[7:0]   = rx_data;
            2'd1: wbuf_d[15:8]  = rx_data;
            2'd2: wbuf_d[23:16] = rx_data;
            default: begin
              mem_wen_d   = 1'b1;
              mem_addr_d  = widx_q[ADDR_W-1:0];
              mem_wdata_d = {rx_data, wbuf_q};
              widx_d      = widx_q + 16'd1;
              if (widx_q == len_q - 16'd1) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end
      StCsum: begin
        if (rx_valid) begin
          // A valid image sums to zero once its own checksum byte is added.
          state_d = (sum_next == 8'd0) ? StDone : StErr;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (in_image && !rx_valid && (idle_q >= IdleLast)) begin
      state_d = StErr;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      widx_q      <= '0;
      bidx_q      <= '0;
      wbuf_q      <= '0;
      csum_q      <= '0;
      idle_q      <= '0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      wbuf_q      <= wbuf_d;
      csum_q      <= csum_d;
      idle_q      <= idle_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Status flags are decoded directly from the state.
  always_comb begin
    busy       = in_image;
    done       = (state_q == StDone);
    cpu_resetn = (state_q == StDone);
    error      = (state_q == StErr);
  end

  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
